// File: rtl/gx_rst_pkg.sv
// Shared types and defaults for the GX channel reset sequencer.
// The output decode lives here so every state's pin levels are in one table.
package gx_rst_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_PWRDN_CYCLES  = 190;
    localparam int DEF_PLL_TIMEOUT   = 50000;
    localparam int DEF_LTR_CYCLES    = 2500;
    localparam int DEF_RX_DIG_CYCLES = 200;
    localparam int DEF_MAX_RETRY     = 3;

    typedef enum logic [2:0] {
        S_PWRDN     = 3'd0,
        S_WAIT_PLL  = 3'd1,
        S_TX_REL    = 3'd2,
        S_RX_ANA    = 3'd3,
        S_WAIT_FREQ = 3'd4,
        S_RX_DIG    = 3'd5,
        S_READY     = 3'd6,
        S_FAULT     = 3'd7
    } state_e;

    typedef struct packed {
        logic gxb_powerdown;
        logic pll_areset;
        logic tx_digitalreset;
        logic rx_analogreset;
        logic rx_digitalreset;
        logic rx_locktorefclk;
        logic rx_locktodata;
        logic ready;
        logic fault;
    } outs_t;

    function automatic outs_t decode_outs(state_e s);
        outs_t o;
        o.gxb_powerdown   = (s == S_PWRDN) || (s == S_FAULT);
        o.pll_areset      = (s == S_PWRDN) || (s == S_FAULT);
        o.tx_digitalreset = s inside {S_PWRDN, S_WAIT_PLL, S_FAULT};
        o.rx_analogreset  = s inside {S_PWRDN, S_WAIT_PLL, S_TX_REL, S_FAULT};
        o.rx_digitalreset = (s != S_READY);
        o.rx_locktodata   = s inside {S_WAIT_FREQ, S_RX_DIG, S_READY};
        o.rx_locktorefclk = !(s inside {S_WAIT_FREQ, S_RX_DIG, S_READY});
        o.ready           = (s == S_READY);
        o.fault           = (s == S_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/gx_sync2.sv
// Two-flop level synchronizer for the asynchronous lock indicators.
module gx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gx_reset_sequencer.sv
// Handshake-driven reset and CDR-mode sequencer for one transceiver channel.
// Outputs are registered decodes of the next state, so they move on the entry edge.
module gx_reset_sequencer
    import gx_rst_pkg::*;
#(
    parameter int unsigned PWRDN_CYCLES  = DEF_PWRDN_CYCLES,
    parameter int unsigned PLL_TIMEOUT   = DEF_PLL_TIMEOUT,
    parameter int unsigned LTR_CYCLES    = DEF_LTR_CYCLES,
    parameter int unsigned RX_DIG_CYCLES = DEF_RX_DIG_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gxb_pwrdn_in,
    input  logic       pll_locked,
    input  logic       rx_freqlocked,
    input  logic       reconfig_busy,
    output logic       gxb_powerdown,
    output logic       pll_areset,
    output logic       tx_digitalreset,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       rx_locktorefclk,
    output logic       rx_locktodata,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] PWRDN_LAST  = CNT_W'(PWRDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LTR_LAST    = CNT_W'(LTR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_DIG_LAST = CNT_W'(RX_DIG_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    logic pll_locked_s;
    logic rx_freqlocked_s;

    gx_sync2 u_sync_pll (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (pll_locked_s)
    );

    gx_sync2 u_sync_freq (
        .clk (clk),
        .rst (rst),
        .d_i (rx_freqlocked),
        .q_o (rx_freqlocked_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retry_q, retry_d;
    outs_t            outs_q;

    // Global exits are checked first so a simultaneous timer expiry is dropped.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (gxb_pwrdn_in && (state_q != S_PWRDN)) begin
            state_d = S_PWRDN;
            if (state_q == S_FAULT) begin
                retry_d = 2'd0;
            end
        end else if (!pll_locked_s &&
                     (state_q inside {S_TX_REL, S_RX_ANA, S_WAIT_FREQ, S_RX_DIG, S_READY})) begin
            state_d = S_WAIT_PLL;
        end else if (!rx_freqlocked_s && (state_q == S_READY)) begin
            state_d = S_RX_ANA;
        end else begin
            unique case (state_q)
                S_PWRDN:     if (!gxb_pwrdn_in && (cnt_q == PWRDN_LAST)) state_d = S_WAIT_PLL;
                S_WAIT_PLL: begin
                    if (pll_locked_s) begin
                        state_d = S_TX_REL;
                    end else if (cnt_q == PLL_LAST) begin
                        retry_d = retry_q + 2'd1;
                        state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_PWRDN;
                    end
                end
                S_TX_REL:    if (!reconfig_busy) state_d = S_RX_ANA;
                S_RX_ANA:    if (cnt_q == LTR_LAST) state_d = S_WAIT_FREQ;
                S_WAIT_FREQ: if (rx_freqlocked_s) state_d = S_RX_DIG;
                S_RX_DIG: begin
                    if (!rx_freqlocked_s)           state_d = S_RX_ANA;
                    else if (cnt_q == RX_DIG_LAST) state_d = S_READY;
                end
                S_READY:     state_d = S_READY;
                S_FAULT:     state_d = S_FAULT;
                default:     state_d = S_PWRDN;
            endcase
        end
        // Reaching link-up counts as a clean start.
        if (state_d == S_READY) begin
            retry_d = 2'd0;
        end
    end

    // A held powerdown request pins the counter so the full hold restarts on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PWRDN;
            cnt_q   <= '0;
            retry_q <= 2'd0;
            outs_q  <= decode_outs(S_PWRDN);
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            outs_q  <= decode_outs(state_d);
            if ((state_d != state_q) || ((state_q == S_PWRDN) && gxb_pwrdn_in)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign gxb_powerdown   = outs_q.gxb_powerdown;
    assign pll_areset      = outs_q.pll_areset;
    assign tx_digitalreset = outs_q.tx_digitalreset;
    assign rx_analogreset  = outs_q.rx_analogreset;
    assign rx_digitalreset = outs_q.rx_digitalreset;
    assign rx_locktorefclk = outs_q.rx_locktorefclk;
    assign rx_locktodata   = outs_q.rx_locktodata;
    assign ready           = outs_q.ready;
    assign fault           = outs_q.fault;
    assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_gx_reset_sequencer.sv
// Scoreboard bench: expected output changes (cycle + pin vector) are queued up front,
// and a negedge monitor pops one entry each time the DUT's output vector changes.
module tb_gx_reset_sequencer;

    localparam int PWRDN_CYCLES  = 10;
    localparam int PLL_TIMEOUT   = 100;
    localparam int LTR_CYCLES    = 50;
    localparam int RX_DIG_CYCLES = 20;
    localparam int MAX_RETRY     = 2;

    // Pin order: powerdown, areset, txrst, rxana, rxdig, ltr, ltd, ready, fault
    localparam logic [8:0] V_PWRDN    = 9'b111111000;
    localparam logic [8:0] V_WAIT_PLL = 9'b001111000;
    localparam logic [8:0] V_TX_REL   = 9'b000111000;
    localparam logic [8:0] V_RX_ANA   = 9'b000011000;
    localparam logic [8:0] V_WFREQ    = 9'b000010100;
    localparam logic [8:0] V_READY    = 9'b000000110;
    localparam logic [8:0] V_FAULT    = 9'b111111001;

    localparam int IN_PLL   = 0;
    localparam int IN_FREQ  = 1;
    localparam int IN_BUSY  = 2;
    localparam int IN_PWRDN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gxb_pwrdn_in = 1'b0;
    logic       pll_locked = 1'b0;
    logic       rx_freqlocked = 1'b0;
    logic       reconfig_busy = 1'b0;
    logic       gxb_powerdown, pll_areset, tx_digitalreset, rx_analogreset;
    logic       rx_digitalreset, rx_locktorefclk, rx_locktodata, ready, fault;
    logic [1:0] retry_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [10:0] vec;
    } exp_t;

    exp_t expQ[$];

    logic [10:0] dutVec;
    assign dutVec = {gxb_powerdown, pll_areset, tx_digitalreset, rx_analogreset,
                     rx_digitalreset, rx_locktorefclk, rx_locktodata, ready, fault, retry_cnt};

    gx_reset_sequencer #(
        .PWRDN_CYCLES  (PWRDN_CYCLES),
        .PLL_TIMEOUT   (PLL_TIMEOUT),
        .LTR_CYCLES    (LTR_CYCLES),
        .RX_DIG_CYCLES (RX_DIG_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gxb_pwrdn_in    (gxb_pwrdn_in),
        .pll_locked      (pll_locked),
        .rx_freqlocked   (rx_freqlocked),
        .reconfig_busy   (reconfig_busy),
        .gxb_powerdown   (gxb_powerdown),
        .pll_areset      (pll_areset),
        .tx_digitalreset (tx_digitalreset),
        .rx_analogreset  (rx_analogreset),
        .rx_digitalreset (rx_digitalreset),
        .rx_locktorefclk (rx_locktorefclk),
        .rx_locktodata   (rx_locktodata),
        .ready           (ready),
        .fault           (fault),
        .retry_cnt       (retry_cnt)
    );

    initial forever #5 clk = ~clk;

    // Free-running edge count; at the negedge after posedge n it reads n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [10:0] actV, input logic [10:0] expV,
                               input int actC, input int expC);
        checks++;
        if ((actV !== expV) || ((expC >= 0) && (actC != expC))) begin
            errors++;
            $display("[TB] FAIL %s: got outputs=%b at cycle %0d, required %b at cycle %0d",
                     name, actV, actC, expV, expC);
        end
    endtask

    task automatic expectAt(input int c, input logic [8:0] v, input logic [1:0] r);
        exp_t e;
        e.cyc = c;
        e.vec = {v, r};
        expQ.push_back(e);
    endtask

    task automatic waitCyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Drive at the negedge of cycle n: the FSM sees synchronous inputs at edge n+1
    // and the lock inputs (through two sync flops) at edge n+3.
    task automatic applyStimulus(input int atCyc, input int sel, input logic val);
        waitCyc(atCyc);
        case (sel)
            IN_PLL:   pll_locked    = val;
            IN_FREQ:  rx_freqlocked = val;
            IN_BUSY:  reconfig_busy = val;
            default:  gxb_pwrdn_in  = val;
        endcase
    endtask

    initial begin : monitor
        logic [10:0] prev;
        exp_t        e;
        @(negedge rst);
        prev = dutVec;
        forever begin
            @(negedge clk);
            if (dutVec !== prev) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_change: got outputs=%b at cycle %0d, required no change",
                             dutVec, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("event@%0d", e.cyc), dutVec, e.vec, cyc, e.cyc);
                end
                prev = dutVec;
            end
        end
    end

    initial begin : stimulus
        #12;
        checkOutput("reset_held", dutVec, {V_PWRDN, 2'd0}, cyc, -1);
        waitCyc(2);
        rst = 1'b0;
        #1 checkOutput("reset_release", dutVec, {V_PWRDN, 2'd0}, cyc, -1);

        // Clean bring-up: PWRDN hold 10, lock seen at 34, RX_ANA 50 cycles, RX_DIG 20 cycles.
        expectAt(12,  V_WAIT_PLL, 2'd0);
        expectAt(34,  V_TX_REL,   2'd0);
        expectAt(35,  V_RX_ANA,   2'd0);
        expectAt(85,  V_WFREQ,    2'd0);
        expectAt(224, V_READY,    2'd0);
        applyStimulus(31,  IN_PLL,  1'b1);
        applyStimulus(201, IN_FREQ, 1'b1);

        // CDR loss after link-up, then relock.
        expectAt(243, V_RX_ANA, 2'd0);
        expectAt(293, V_WFREQ,  2'd0);
        expectAt(323, V_READY,  2'd0);
        applyStimulus(240, IN_FREQ, 1'b0);
        applyStimulus(300, IN_FREQ, 1'b1);

        // PLL loss, relock, and reconfig busy holding TX_REL for 40 cycles.
        expectAt(343, V_WAIT_PLL, 2'd0);
        expectAt(353, V_TX_REL,   2'd0);
        expectAt(393, V_RX_ANA,   2'd0);
        expectAt(443, V_WFREQ,    2'd0);
        expectAt(464, V_READY,    2'd0);
        applyStimulus(340, IN_PLL,  1'b0);
        applyStimulus(350, IN_PLL,  1'b1);
        applyStimulus(352, IN_BUSY, 1'b1);
        applyStimulus(392, IN_BUSY, 1'b0);

        // Powerdown, PLL loss and RX_DIG expiry all land on edge 544.
        expectAt(473, V_RX_ANA, 2'd0);
        expectAt(523, V_WFREQ,  2'd0);
        expectAt(544, V_PWRDN,  2'd0);
        applyStimulus(470, IN_FREQ,  1'b0);
        applyStimulus(520, IN_FREQ,  1'b1);
        applyStimulus(541, IN_PLL,   1'b0);
        applyStimulus(543, IN_PWRDN, 1'b1);
        waitCyc(555);
        checkOutput("pwrdn_hold", dutVec, {V_PWRDN, 2'd0}, cyc, -1);

        // PLL never locks: retry, then fault, then software powerdown clears it.
        expectAt(570, V_WAIT_PLL, 2'd0);
        expectAt(670, V_PWRDN,    2'd1);
        expectAt(680, V_WAIT_PLL, 2'd1);
        expectAt(780, V_FAULT,    2'd2);
        expectAt(801, V_PWRDN,    2'd0);
        expectAt(811, V_WAIT_PLL, 2'd0);
        applyStimulus(560, IN_PWRDN, 1'b0);
        waitCyc(790);
        checkOutput("fault_hold", dutVec, {V_FAULT, 2'd2}, cyc, -1);
        applyStimulus(800, IN_PWRDN, 1'b1);
        applyStimulus(801, IN_PWRDN, 1'b0);

        // Bring-up again, then async reset in the middle of RX_DIG.
        expectAt(823, V_TX_REL, 2'd0);
        expectAt(824, V_RX_ANA, 2'd0);
        expectAt(874, V_WFREQ,  2'd0);
        expectAt(885, V_PWRDN,  2'd0);
        applyStimulus(820, IN_PLL, 1'b1);
        waitCyc(884);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", dutVec, {V_PWRDN, 2'd0}, cyc, -1);

        // After release the synchronizers refill, so the sequence restarts from PWRDN.
        expectAt(900, V_WAIT_PLL, 2'd0);
        expectAt(901, V_TX_REL,   2'd0);
        expectAt(902, V_RX_ANA,   2'd0);
        expectAt(952, V_WFREQ,    2'd0);
        expectAt(973, V_READY,    2'd0);
        waitCyc(890);
        rst = 1'b0;

        waitCyc(1000);
        checkOutput("final_ready", dutVec, {V_READY, 2'd0}, cyc, -1);
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_event@%0d: got no output change, required %b", e.cyc, e.vec);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
